mem_op_aligner: RTL and testbench
=================================

# mem_op_aligner

Parametrised memory-operation front end between a core-side requester and an L1 cache (ICACHE or DCACHE). It accepts one STORE/LOAD/CLFLUSH request of BYTE/HALF/WORD (or DOUBLE when XLEN=64) size at any byte address. It converts the request into one or two XLEN-aligned bus beats with byte enables, splitting any access that crosses an XLEN boundary. For loads, it reassembles the beats and sign- or zero-extends the result.

## Interface
- XLEN, 32: data width, 32 or 64; NB = XLEN/8 byte lanes.
- ADDR_W, 32: address width.
- L1_TYPE, 2'd0 (UNASSIGNED): 1=ICACHE (STORE is illegal), 2=DCACHE.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1  request handshake.
- req_op  in  2  STORE=00, LOAD=01, CLFLUSH=11; 10 is illegal.
- req_size  in  2  BYTE=00, HALF=01, WORD=10, DOUBLE=11 (DOUBLE is legal only when XLEN=64).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- req_signed  in  1  sign-extend load result.
- bus_valid / bus_ready  out / in  1  beat handshake.
- bus_op  out  2  copy of the accepted op.
- bus_addr  out  ADDR_W  NB-aligned address.
- bus_be  out  NB  byte enables.
- bus_wdata  out  XLEN  lane-positioned store data.
- bus_rvalid  in  1  beat completion, for loads and stores alike.
- bus_rdata  in  XLEN  load data for the completed beat.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  XLEN  load result; 0 for STORE, CLFLUSH and errors.
- rsp_err  out  1  illegal request.
- rsp_split  out  1  the request used two beats.

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP, ERR. req_ready=1 only in IDLE.
- Acceptance (IDLE and req_valid) latches op, size, addr, wdata and signed.
  - Illegal request → ERR. Illegal means op=10, DOUBLE with XLEN=32, or STORE with L1_TYPE=ICACHE.
  - Any other request → ISSUE0.
- Beat computation (let off = addr mod NB, n = 1<<size):
  - split = (off+n > NB) and op≠CLFLUSH.
  - Beat 0: addr = addr with low log2(NB) bits cleared; be = ((1<<n)-1)<<off, truncated to NB bits; wdata = wdata<<(8*off).
  - Beat 1: addr = beat0 addr + NB, modulo 2^ADDR_W (wraps at the top of memory); be = ((1<<n)-1)>>(NB-off); wdata = wdata>>(8*(NB-off)).
  - CLFLUSH: single beat, be all ones, size ignored.
- ISSUE0 / ISSUE1: bus_valid=1, with outputs stable until bus_ready; then go to WAIT0 / WAIT1.
- WAIT0 on bus_rvalid: capture bus_rdata>>(8*off) into the low part of the assembly register; go to ISSUE1 if split, else RESP.
- WAIT1 on bus_rvalid: OR in bus_rdata<<(8*(NB-off)); go to RESP.
- RESP: rsp_valid=1. rsp_rdata = assembly truncated to n bytes, then sign-extended from bit 8n-1 if signed, else zero-extended. Then go to IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0, no bus traffic; then go to IDLE.
- bus_rvalid is ignored outside WAIT0/WAIT1. At most one beat is outstanding.

## Timing
- Reset (asynchronous, reset_n low): state=IDLE. All outputs 0 except req_ready=1. Latched request and assembly register cleared.
- Reset mid-operation aborts immediately. A late bus_rvalid after reset is ignored.
- Accept at cycle T:
  - bus_valid rises at T+1.
  - WAIT is entered the cycle after the bus_valid/bus_ready handshake. bus_rvalid is sampled no earlier than that.
  - rsp_valid is asserted the cycle after the final bus_rvalid.
- Minimum latency, accept to rsp_valid: aligned = 3 cycles; split = 5 cycles; error = 1 cycle.
- The next request can be accepted the cycle after rsp_valid.
- Sign/zero extension uses the full XLEN. DOUBLE is never extended.

## Test plan
- **Aligned LOAD WORD** at 0x1000, XLEN=32: bus beat addr 0x1000, be 1111. bus_rdata 0x12345678 → rsp_rdata 0x12345678, rsp_split=0, rsp_valid at T+3 with zero-wait bus.
- **Split STORE HALF** at 0x1003, wdata 0xBEEF:
  - beat0 addr 0x1000, be 1000, wdata 0xEF000000;
  - beat1 addr 0x1004, be 0001, wdata 0x000000BE;
  - rsp_split=1.
- **Split signed LOAD WORD** at 0x2002: beat0 rdata 0x8765AAAA, beat1 rdata 0x5555CAFE → rsp_rdata 0xCAFE8765.
- **Signed LOAD BYTE** at 0x3001, rdata 0x00008000 → 0xFFFFFF80. The same load unsigned → 0x00000080.
- **Flush and illegal requests:**
  - CLFLUSH at 0x4007 → single beat, addr 0x4004, op 11, be 1111.
  - op=10 → rsp_err=1 at T+1, bus_valid never asserted.
  - STORE with L1_TYPE=ICACHE → rsp_err=1 at T+1, bus_valid never asserted.
- **Wrap and reset:**
  - LOAD WORD at 0xFFFFFFFE → beat1 addr 0x00000000.
  - reset_n pulsed low during WAIT1 → outputs at reset values, req_ready=1; a following bus_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/mem_op_aligner.sv
// Memory-operation front end: turns one core request into one or two XLEN-aligned
// cache beats with byte enables, and reassembles and extends load data.
module mem_op_aligner #(
    parameter int         XLEN    = 32,
    parameter int         ADDR_W  = 32,
    parameter logic [1:0] L1_TYPE = 2'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_signed,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_split
);
    // state    | meaning
    // S_IDLE   | ready for a request
    // S_ISSUE0 | first beat presented on the bus
    // S_WAIT0  | waiting for first beat completion
    // S_ISSUE1 | second beat of a split access presented
    // S_WAIT1  | waiting for second beat completion
    // S_RESP   | one-cycle response with assembled data
    // S_ERR    | one-cycle error response, no bus traffic

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int SHW  = OFFW + 4;

    localparam logic [1:0] OP_STORE   = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_CLFLUSH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_RESP, S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        op_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              signed_q;
    logic [XLEN-1:0]   asm_q;

    logic              accept;
    logic              illegal;
    logic [OFFW-1:0]   off;
    logic [3:0]        nbytes;
    logic [NB-1:0]     nmask;
    logic              split;
    logic [SHW-1:0]    sh0;
    logic [SHW-1:0]    sh1;
    logic [2*NB-1:0]   be_wide;
    logic [2*XLEN-1:0] wd_wide;
    logic [ADDR_W-1:0] beat0_addr;
    logic [ADDR_W-1:0] beat1_addr;
    logic [XLEN-1:0]   rd_lo;
    logic [XLEN-1:0]   rd_hi;
    logic [XLEN-1:0]   ext_data;
    logic              sbit;
    int                nbits;

    assign accept  = (state_q == S_IDLE) && req_valid;
    assign illegal = (req_op == 2'b10)
                  || ((req_size == 2'b11) && (XLEN != 64))
                  || ((req_op == OP_STORE) && (L1_TYPE == 2'd1));

    assign off    = addr_q[OFFW-1:0];
    assign nbytes = 4'd1 << size_q;
    assign split  = ((5'(off) + 5'(nbytes)) > 5'(NB)) && (op_q != OP_CLFLUSH);
    assign sh0    = SHW'({off, 3'b000});
    assign sh1    = SHW'(XLEN) - sh0;

    always_comb begin
        nmask = '0;
        for (int i = 0; i < NB; i++) begin
            nmask[i] = (i < int'(nbytes));
        end
    end

    // Upper halves of the widened shifts are exactly the second-beat lanes.
    assign be_wide    = {{NB{1'b0}}, nmask} << off;
    assign wd_wide    = {{XLEN{1'b0}}, wdata_q} << sh0;
    assign beat0_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign beat1_addr = beat0_addr + ADDR_W'(NB);
    assign rd_lo      = bus_rdata >> sh0;
    assign rd_hi      = bus_rdata << sh1;

    always_comb begin
        nbits    = 8 << size_q;
        sbit     = 1'b0;
        ext_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == nbits - 1) sbit = asm_q[i];
        end
        for (int i = 0; i < XLEN; i++) begin
            ext_data[i] = (i < nbits) ? asm_q[i] : (signed_q & sbit);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            signed_q <= 1'b0;
            asm_q    <= '0;
        end else begin
            if (accept) begin
                op_q     <= req_op;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                signed_q <= req_signed;
                asm_q    <= '0;
            end
            if ((state_q == S_WAIT0) && bus_rvalid) asm_q <= rd_lo;
            if ((state_q == S_WAIT1) && bus_rvalid) asm_q <= asm_q | rd_hi;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = illegal ? S_ERR : S_ISSUE0;
            S_ISSUE0: if (bus_ready) state_d = S_WAIT0;
            S_WAIT0:  if (bus_rvalid) state_d = split ? S_ISSUE1 : S_RESP;
            S_ISSUE1: if (bus_ready) state_d = S_WAIT1;
            S_WAIT1:  if (bus_rvalid) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        bus_valid = 1'b0;
        bus_op    = '0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        rsp_split = 1'b0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_ISSUE0: begin
                bus_valid = 1'b1;
                bus_op    = op_q;
                bus_addr  = beat0_addr;
                bus_be    = (op_q == OP_CLFLUSH) ? {NB{1'b1}} : be_wide[NB-1:0];
                bus_wdata = wd_wide[XLEN-1:0];
            end
            S_ISSUE1: begin
                bus_valid = 1'b1;
                bus_op    = op_q;
                bus_addr  = beat1_addr;
                bus_be    = be_wide[2*NB-1:NB];
                bus_wdata = wd_wide[2*XLEN-1:XLEN];
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_split = split;
                rsp_rdata = (op_q == OP_LOAD) ? ext_data : '0;
            end
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_op_aligner.sv
// Directed bench for mem_op_aligner (XLEN=32): zero-wait bus responder, beat capture
// and response checks against hand-computed values.
module tb_mem_op_aligner;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, ic_req_valid;
    logic [1:0]  req_op, req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_signed;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    logic        req_ready, bus_valid, rsp_valid, rsp_err, rsp_split;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr, bus_wdata, rsp_rdata;
    logic [3:0]  bus_be;

    logic        ic_req_ready, ic_bus_valid, ic_rsp_valid, ic_rsp_err, ic_rsp_split;
    logic [1:0]  ic_bus_op;
    logic [31:0] ic_bus_addr, ic_bus_wdata, ic_rsp_rdata;
    logic [3:0]  ic_bus_be;

    int checks   = 0;
    int failures = 0;

    logic [31:0] b_addr [2];
    logic [3:0]  b_be   [2];
    logic [31:0] b_wd   [2];
    logic [1:0]  b_op;
    int          nbeats, got_lat;
    logic [31:0] r_rdata;
    logic        r_err, r_split;

    always #5 clk = ~clk;

    mem_op_aligner #(.XLEN(32), .ADDR_W(32), .L1_TYPE(2'd2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_signed(req_signed),
        .bus_valid(bus_valid), .bus_ready(1'b1), .bus_op(bus_op),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_split(rsp_split)
    );

    mem_op_aligner #(.XLEN(32), .ADDR_W(32), .L1_TYPE(2'd1)) dut_ic (
        .clk(clk), .reset_n(reset_n),
        .req_valid(ic_req_valid), .req_ready(ic_req_ready),
        .req_op(req_op), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_signed(req_signed),
        .bus_valid(ic_bus_valid), .bus_ready(1'b1), .bus_op(ic_bus_op),
        .bus_addr(ic_bus_addr), .bus_be(ic_bus_be), .bus_wdata(ic_bus_wdata),
        .bus_rvalid(1'b0), .bus_rdata(32'h0),
        .rsp_valid(ic_rsp_valid), .rsp_rdata(ic_rsp_rdata),
        .rsp_err(ic_rsp_err), .rsp_split(ic_rsp_split)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, answer each beat with rd0/rd1 one cycle after it is seen,
    // and record beats, response and latency in negedges after the accept edge.
    task automatic run_req(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic sg,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        bit done = 0;
        bit pend = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_size = sz; req_addr = addr;
        req_wdata = wd; req_signed = sg;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        nbeats = 0; got_lat = 0; r_rdata = '0; r_err = 1'b0; r_split = 1'b0; b_op = '0;
        b_addr[0] = '0; b_addr[1] = '0; b_be[0] = '0; b_be[1] = '0; b_wd[0] = '0; b_wd[1] = '0;
        for (int k = 1; k <= 20 && !done; k++) begin
            if (k > 1) @(negedge clk);
            bus_rvalid = 1'b0;
            if (rsp_valid) begin
                got_lat = k; r_rdata = rsp_rdata; r_err = rsp_err; r_split = rsp_split;
                done = 1;
            end else begin
                if (pend) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = (nbeats == 1) ? rd0 : rd1;
                    pend = 0;
                end
                if (bus_valid) begin
                    if (nbeats < 2) begin
                        b_addr[nbeats] = bus_addr; b_be[nbeats] = bus_be;
                        b_wd[nbeats] = bus_wdata; b_op = bus_op;
                    end
                    nbeats++;
                    pend = 1;
                end
            end
        end
        bus_rvalid = 1'b0;
        if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0; req_valid = 1'b0; ic_req_valid = 1'b0;
        req_op = '0; req_size = '0; req_addr = '0; req_wdata = '0; req_signed = 1'b0;
        bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        reset_n = 1'b1;

        run_req(2'b01, 2'b10, 32'h0000_1000, 32'h0, 1'b0, 32'h1234_5678, 32'h0);
        chk("al_beats", 32'(nbeats), 32'd1);
        chk("al_addr", b_addr[0], 32'h0000_1000);
        chk("al_be", 32'(b_be[0]), 32'hF);
        chk("al_rdata", r_rdata, 32'h1234_5678);
        chk("al_split", 32'(r_split), 32'd0);
        chk("al_lat", 32'(got_lat), 32'd3);
        @(negedge clk);
        chk("al_pulse", 32'(rsp_valid), 32'd0);
        chk("al_ready", 32'(req_ready), 32'd1);

        run_req(2'b00, 2'b01, 32'h0000_1003, 32'h0000_BEEF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("st_beats", 32'(nbeats), 32'd2);
        chk("st_addr0", b_addr[0], 32'h0000_1000);
        chk("st_be0", 32'(b_be[0]), 32'h8);
        chk("st_wd0", b_wd[0], 32'hEF00_0000);
        chk("st_addr1", b_addr[1], 32'h0000_1004);
        chk("st_be1", 32'(b_be[1]), 32'h1);
        chk("st_wd1", b_wd[1], 32'h0000_00BE);
        chk("st_op", 32'(b_op), 32'h0);
        chk("st_split", 32'(r_split), 32'd1);
        chk("st_rdata", r_rdata, 32'h0);
        chk("st_lat", 32'(got_lat), 32'd5);

        run_req(2'b01, 2'b10, 32'h0000_2002, 32'h0, 1'b1, 32'h8765_AAAA, 32'h5555_CAFE);
        chk("sl_be0", 32'(b_be[0]), 32'hC);
        chk("sl_be1", 32'(b_be[1]), 32'h3);
        chk("sl_rdata", r_rdata, 32'hCAFE_8765);
        chk("sl_split", 32'(r_split), 32'd1);

        run_req(2'b01, 2'b00, 32'h0000_3001, 32'h0, 1'b1, 32'h0000_8000, 32'h0);
        chk("sb_be", 32'(b_be[0]), 32'h2);
        chk("sb_rdata", r_rdata, 32'hFFFF_FF80);
        run_req(2'b01, 2'b00, 32'h0000_3001, 32'h0, 1'b0, 32'h0000_8000, 32'h0);
        chk("ub_rdata", r_rdata, 32'h0000_0080);
        run_req(2'b01, 2'b01, 32'h0000_3002, 32'h0, 1'b1, 32'h9ABC_0000, 32'h0);
        chk("sh_rdata", r_rdata, 32'hFFFF_9ABC);

        run_req(2'b11, 2'b00, 32'h0000_4007, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("fl_beats", 32'(nbeats), 32'd1);
        chk("fl_addr", b_addr[0], 32'h0000_4004);
        chk("fl_op", 32'(b_op), 32'h3);
        chk("fl_be", 32'(b_be[0]), 32'hF);
        chk("fl_split", 32'(r_split), 32'd0);

        run_req(2'b10, 2'b10, 32'h0000_5000, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("op10_err", 32'(r_err), 32'd1);
        chk("op10_lat", 32'(got_lat), 32'd1);
        chk("op10_beats", 32'(nbeats), 32'd0);
        chk("op10_rdata", r_rdata, 32'h0);
        run_req(2'b01, 2'b11, 32'h0000_5000, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("dbl_err", 32'(r_err), 32'd1);
        chk("dbl_beats", 32'(nbeats), 32'd0);

        @(negedge clk);
        chk("ic_ready", 32'(ic_req_ready), 32'd1);
        req_op = 2'b00; req_size = 2'b10; req_addr = 32'h0000_6000; req_wdata = 32'h1;
        ic_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ic_req_valid = 1'b0;
        chk("ic_rsp_valid", 32'(ic_rsp_valid), 32'd1);
        chk("ic_rsp_err", 32'(ic_rsp_err), 32'd1);
        chk("ic_bus_valid", 32'(ic_bus_valid), 32'd0);
        @(negedge clk);
        chk("ic_bus_valid2", 32'(ic_bus_valid), 32'd0);
        chk("ic_rsp_done", 32'(ic_rsp_valid), 32'd0);

        run_req(2'b01, 2'b10, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'h1111_2222, 32'h3333_4444);
        chk("wr_addr0", b_addr[0], 32'hFFFF_FFFC);
        chk("wr_addr1", b_addr[1], 32'h0000_0000);
        chk("wr_rdata", r_rdata, 32'h4444_1111);

        // Abort a split load while it waits for its second beat.
        @(negedge clk);
        req_op = 2'b01; req_size = 2'b10; req_addr = 32'h0000_2002; req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ab_issue0", 32'(bus_valid), 32'd1);
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'hAAAA_BBBB;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("ab_issue1", bus_addr, 32'h0000_2004);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("ab_req_ready", 32'(req_ready), 32'd1);
        chk("ab_bus_valid", 32'(bus_valid), 32'd0);
        chk("ab_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ab_bus_addr", bus_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_6666;
        @(negedge clk);
        bus_rvalid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid || bus_valid) cnt++;
            @(negedge clk);
        end
        chk("ab_late_rvalid", 32'(cnt), 32'd0);

        run_req(2'b01, 2'b10, 32'h0000_7000, 32'h0, 1'b0, 32'hCAFE_F00D, 32'h0);
        chk("post_rdata", r_rdata, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
